frac_sad_search: RTL and testbench
==================================

# frac_sad_search

Fractional-pel motion refinement engine for the motion-estimation datapath. It streams one block's reference neighbourhood and original pixels line by line, and builds 5×5 quarter-pel candidates around the integer best match by bilinear interpolation. It accumulates a full-block SAD per candidate, then scans the candidates sequentially. It returns the best fractional offset and its SAD over a valid/ready handshake to the motion-vector selection stage.

## Interface
- `BD`, 8, pixel bit depth
- `BLK_W`, 8, block width in pixels
- `BLK_H`, 8, block height in lines
- `SAD_W` (localparam), BD + $clog2(BLK_W*BLK_H), SAD/accumulator width

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block accepts a beat
- `ref_line`  in  (BLK_W+2)*BD  reference line, pixel x=-1 at LSBs through x=BLK_W at MSBs
- `org_line`  in  BLK_W*BD  original line, pixel x=0 at LSBs; ignored on beats 0 and 1
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_dx`  out  3  signed best horizontal offset, quarter-pel, -2..+2
- `out_dy`  out  3  signed best vertical offset, quarter-pel, -2..+2
- `out_sad`  out  SAD_W  SAD of the best candidate

## Operation
- A block is BLK_H+2 beats. Beat b carries reference row y=b-1, so rows -1..BLK_H are covered. Beat b≥2 also carries original row b-2.
- Two line registers hold the previous two reference lines. On beat b≥2 the upper, middle and lower rows are rows b-3, b-2 and b-1.
- Candidate (dx,dy), d∈{-2..2}:
  - integer part i=floor(d/4) ∈ {-1,0}, fraction f=d mod 4.
  - Sample = (w00·A + w01·B + w10·C + w11·D + R) >> 4, with weights (4-fx)(4-fy), fx(4-fy), (4-fx)fy, fx·fy.
  - A..D are the neighbours at the integer position.
  - R=8 with rounding, 0 without (see Configuration).
- Stage 1 (registered, on beat acceptance): 25 line SADs, each sum over x of |org - sample|.
- Stage 2: the 25 accumulators add the stage-1 values. Accepting beat 0 clears all accumulators.
- Candidate index k = (dy+2)·5 + (dx+2).
- FSM:
  - LOAD: in_ready=1; beat counter 0..BLK_H+1. The last beat moves to FLUSH.
  - FLUSH: 1 cycle; final accumulate; moves to SCAN.
  - SCAN: 25 cycles. Evaluation order is k=12 (centre) first, then k=0..24 skipping 12. A candidate replaces the best only if its SAD is strictly less. The centre therefore wins ties; otherwise the lowest k wins. Moves to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready, move to LOAD.
- in_ready=0 in FLUSH, SCAN and DONE. in_valid is ignored there.
- Interpolation intermediates are BD+4+1 bits wide. Accumulators never overflow by construction.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_dx=0, out_dy=0, out_sad=0
  - state LOAD, beat counter 0, accumulators 0
- Beats may have bubbles: the counter advances only on in_valid&&in_ready.
- Latency: the last beat is accepted at edge E. out_valid rises after edge E+26.
- Outputs are held stable while out_valid && !out_ready.
- in_ready rises the cycle after the output handshake. A new beat 0 is accepted that cycle, so there is no dead cycle.
- rst_n low at any point, including mid-block, mid-scan or during DONE, aborts immediately to the reset values. Partial sums are discarded.

## Configuration
- `FRAC_INTERP_ROUND_EN`:
  - defined: R=8, round-to-nearest interpolation.
  - undefined: R=0, truncating interpolation, matching the legacy per-line difference datapath.
- No other behaviour changes.

## Test plan
- Flat: all ref=100, all org=100, BLK 8×8 → dx=0, dy=0, sad=0. Centre wins the 25-way tie.
- Horizontal ramp: ref(x)=4x, org(x)=4x+1 → dx=+1, dy=0, sad=0, in both macro settings.
- Rounding: ref columns alternate, odd x=1 and even x=0; org all 1.
  - With the macro: dx=-2, dy=-2, sad=0.
  - Without the macro: dx=0, dy=0, sad=32.
- Backpressure: out_ready low for 10 cycles after out_valid → outputs constant and in_ready=0 throughout. in_ready=1 the cycle after the handshake.
- Reset mid-block: rst_n pulsed low after beat 3 → out_valid=0 and in_ready=1 immediately. A following full ramp block returns dx=+1, sad=0.
- Bubbles: the ramp block with in_valid low on alternate cycles → identical result. out_valid comes 26 edges after the last accepted beat.

Source files
------------

// File: rtl/frac_sad_search.sv
// Purpose  : quarter-pel motion refinement; 5x5 bilinear candidates around the integer match, full-block SAD each, best picked by scan.
// Latency  : out_valid rises after edge E+26, where E is the edge accepting the last beat (1 flush cycle + 25 scan cycles).
// Backpress: in_ready is high only while loading; the result is held stable in DONE until out_ready, and loading resumes the next cycle.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready with ref_line ((BLK_W+2) pixels, x=-1 at LSBs)
//        and org_line (BLK_W pixels, x=0 at LSBs, ignored on beats 0/1); out_valid/out_ready with
//        out_dx/out_dy (signed quarter-pel, -2..+2) and out_sad.
// Option : define FRAC_INTERP_ROUND_EN for round-to-nearest interpolation (default truncates).
module frac_sad_search #(
    parameter int BD    = 8,
    parameter int BLK_W = 8,
    parameter int BLK_H = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [(BLK_W+2)*BD-1:0]         ref_line,
    input  logic [BLK_W*BD-1:0]             org_line,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [2:0]               out_dx,
    output logic signed [2:0]               out_dy,
    output logic [BD+$clog2(BLK_W*BLK_H)-1:0] out_sad
);

    localparam int SAD_W = BD + $clog2(BLK_W*BLK_H);
    localparam int IW    = BD + 5;
    localparam int BW    = $clog2(BLK_H + 2);
    localparam int NC    = 25;
    localparam int LW    = (BLK_W + 2) * BD;
`ifdef FRAC_INTERP_ROUND_EN
    localparam logic [IW-1:0] RND = IW'(8);
`else
    localparam logic [IW-1:0] RND = IW'(0);
`endif

    typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_SCAN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [4:0]         scan_q, scan_d;

    // mid_q holds the previous beat's line, up_q the one before it.
    logic [LW-1:0]      mid_q, up_q;
    logic [SAD_W-1:0]   line_sad [NC];
    logic [SAD_W-1:0]   s1_sad_q [NC];
    logic               s1_vld_q;
    logic [SAD_W-1:0]   acc_q    [NC];

    logic [SAD_W-1:0]   best_sad_q;
    logic signed [2:0]  best_dx_q, best_dy_q;

    logic               accept;
    logic [4:0]         cand_k;
    logic [SAD_W-1:0]   cand_sad;
    logic signed [2:0]  cand_dx, cand_dy;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Candidate line SADs. Candidate (dx,dy) sits at index (dy+2)*5+(dx+2).
    // Integer part -1 for d<0, 0 otherwise; fraction is d mod 4.
    // ------------------------------------------------------------------
    for (genvar cy = 0; cy < 5; cy++) begin : g_cy
        for (genvar cx = 0; cx < 5; cx++) begin : g_cx
            localparam int FX = (cx + 2) % 4;
            localparam int FY = (cy + 2) % 4;
            // Column of neighbour A in ref_line pixel units (x=-1 is column 0).
            localparam int OX = (cx >= 2) ? 1 : 0;
            // dy<0 interpolates between rows y-1/y, otherwise between y/y+1.
            localparam bit LOW = (cy >= 2);
            localparam int K  = cy * 5 + cx;
            localparam logic [IW-1:0] W00 = IW'((4 - FX) * (4 - FY));
            localparam logic [IW-1:0] W01 = IW'(FX * (4 - FY));
            localparam logic [IW-1:0] W10 = IW'((4 - FX) * FY);
            localparam logic [IW-1:0] W11 = IW'(FX * FY);

            logic [LW-1:0]    top, bot;
            logic [IW-1:0]    pa, pb, pc, pd, smp, po, dif;
            logic [SAD_W-1:0] lsad;

            assign top = LOW ? mid_q : up_q;
            assign bot = LOW ? ref_line : mid_q;

            always_comb begin
                lsad = '0;
                pa   = '0;
                pb   = '0;
                pc   = '0;
                pd   = '0;
                smp  = '0;
                po   = '0;
                dif  = '0;
                for (int x = 0; x < BLK_W; x++) begin
                    pa   = IW'(top[(x+OX)*BD +: BD]);
                    pb   = IW'(top[(x+OX+1)*BD +: BD]);
                    pc   = IW'(bot[(x+OX)*BD +: BD]);
                    pd   = IW'(bot[(x+OX+1)*BD +: BD]);
                    smp  = (W00*pa + W01*pb + W10*pc + W11*pd + RND) >> 4;
                    po   = IW'(org_line[x*BD +: BD]);
                    dif  = (smp > po) ? (smp - po) : (po - smp);
                    lsad = lsad + SAD_W'(dif);
                end
            end

            assign line_sad[K] = lsad;
        end
    end

    // ------------------------------------------------------------------
    // Scan order: centre (12) first, then 0..24 skipping 12.
    // ------------------------------------------------------------------
    always_comb begin
        if (scan_q == 5'd0) begin
            cand_k = 5'd12;
        end else if (scan_q <= 5'd12) begin
            cand_k = scan_q - 5'd1;
        end else begin
            cand_k = scan_q;
        end
    end

    assign cand_sad = acc_q[cand_k];
    assign cand_dx  = 3'(cand_k % 5'd5) - 3'd2;
    assign cand_dy  = 3'(cand_k / 5'd5) - 3'd2;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        scan_d    = scan_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (beat_q == BW'(BLK_H + 1)) begin
                        beat_d  = '0;
                        state_d = S_FLUSH;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                scan_d  = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (scan_q == 5'd24) begin
                    state_d = S_DONE;
                end else begin
                    scan_d = scan_q + 5'd1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            beat_q     <= '0;
            scan_q     <= '0;
            mid_q      <= '0;
            up_q       <= '0;
            s1_vld_q   <= 1'b0;
            best_sad_q <= '0;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
            for (int k = 0; k < NC; k++) begin
                s1_sad_q[k] <= '0;
                acc_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            scan_q  <= scan_d;

            if (accept) begin
                up_q  <= mid_q;
                mid_q <= ref_line;
            end

            // Stage 1: capture line SADs once three reference rows are available.
            s1_vld_q <= accept && (beat_q >= BW'(2));
            if (accept && (beat_q >= BW'(2))) begin
                for (int k = 0; k < NC; k++) begin
                    s1_sad_q[k] <= line_sad[k];
                end
            end

            // Stage 2: beat 0 starts a fresh block; the last line lands during FLUSH.
            for (int k = 0; k < NC; k++) begin
                if (accept && (beat_q == '0)) begin
                    acc_q[k] <= '0;
                end else if (s1_vld_q) begin
                    acc_q[k] <= acc_q[k] + s1_sad_q[k];
                end
            end

            // Strictly-less replacement keeps the centre on ties, then the lowest index.
            if ((state_q == S_SCAN) && ((scan_q == 5'd0) || (cand_sad < best_sad_q))) begin
                best_sad_q <= cand_sad;
                best_dx_q  <= cand_dx;
                best_dy_q  <= cand_dy;
            end
        end
    end

    assign out_dx  = best_dx_q;
    assign out_dy  = best_dy_q;
    assign out_sad = best_sad_q;

endmodule

// File: tb/tb_frac_sad_search.sv
`timescale 1ns/1ps
module tb_frac_sad_search;

    localparam int BD    = 8;
    localparam int BLK_W = 8;
    localparam int BLK_H = 8;
    localparam int SAD_W = BD + $clog2(BLK_W*BLK_H);
`ifdef FRAC_INTERP_ROUND_EN
    localparam int RND = 8;
`else
    localparam int RND = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [(BLK_W+2)*BD-1:0]  ref_line = '0;
    logic [BLK_W*BD-1:0]      org_line = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [2:0]        out_dx, out_dy;
    logic [SAD_W-1:0]         out_sad;

    frac_sad_search #(.BD(BD), .BLK_W(BLK_W), .BLK_H(BLK_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ref_line  (ref_line),
        .org_line  (org_line),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dx    (out_dx),
        .out_dy    (out_dy),
        .out_sad   (out_sad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // rimg[r][j] = reference row r-1, pixel j-1; oimg[y][x] = original pixel.
    int rimg [BLK_H+2][BLK_W+2];
    int oimg [BLK_H][BLK_W];
    int n_checks = 0;
    int n_fail   = 0;
    int last_edge = 0;

    typedef struct {
        int pat;
        int edx;
        int edy;
        int esad;
        int hold;
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model straight from the candidate definition.
    task automatic model(output int bdx, output int bdy, output int bsad);
        int sads [25];
        int minv;
        int bk;
        for (int k = 0; k < 25; k++) begin
            int dx, dy, ix, iy, fx, fy, s, smp, a, b, c, d, df;
            dx = k % 5 - 2;
            dy = k / 5 - 2;
            ix = (dx < 0) ? -1 : 0;
            iy = (dy < 0) ? -1 : 0;
            fx = dx - 4 * ix;
            fy = dy - 4 * iy;
            s  = 0;
            for (int y = 0; y < BLK_H; y++) begin
                for (int x = 0; x < BLK_W; x++) begin
                    a   = rimg[y+iy+1][x+ix+1];
                    b   = rimg[y+iy+1][x+ix+2];
                    c   = rimg[y+iy+2][x+ix+1];
                    d   = rimg[y+iy+2][x+ix+2];
                    smp = ((4-fx)*(4-fy)*a + fx*(4-fy)*b + (4-fx)*fy*c + fx*fy*d + RND) / 16;
                    df  = oimg[y][x] - smp;
                    s  += (df < 0) ? -df : df;
                end
            end
            sads[k] = s;
        end
        minv = sads[0];
        for (int k = 1; k < 25; k++) if (sads[k] < minv) minv = sads[k];
        bk = 12;
        if (sads[12] != minv) begin
            for (int k = 24; k >= 0; k--) if (sads[k] == minv) bk = k;
        end
        bdx  = bk % 5 - 2;
        bdy  = bk / 5 - 2;
        bsad = minv;
    endtask

    task automatic fill_pattern(input int pat);
        for (int r = 0; r < BLK_H + 2; r++)
            for (int j = 0; j < BLK_W + 2; j++)
                case (pat)
                    0:       rimg[r][j] = 100;
                    // vertical slope keeps dy=0 the unique zero-SAD candidate
                    1:       rimg[r][j] = 4 * j + 16 * r;
                    default: rimg[r][j] = (j % 2 == 0) ? 1 : 0;
                endcase
        for (int y = 0; y < BLK_H; y++)
            for (int x = 0; x < BLK_W; x++)
                case (pat)
                    0:       oimg[y][x] = 100;
                    1:       oimg[y][x] = 4 * (x + 1) + 16 * (y + 1) + 1;
                    default: oimg[y][x] = 1;
                endcase
    endtask

    task automatic fill_random();
        int mode, ax, ay, c, sx, sy, v;
        mode = $urandom_range(0, 2);
        ax = $urandom_range(0, 9);
        ay = $urandom_range(0, 9);
        c  = $urandom_range(0, 60);
        for (int r = 0; r < BLK_H + 2; r++)
            for (int j = 0; j < BLK_W + 2; j++)
                rimg[r][j] = (mode == 0) ? $urandom_range(0, 255) : c + ax * j + ay * r;
        sx = $urandom_range(0, 2);
        sy = $urandom_range(0, 2);
        for (int y = 0; y < BLK_H; y++)
            for (int x = 0; x < BLK_W; x++) begin
                v = (mode == 2) ? rimg[y+sy][x+sx] + $urandom_range(0, 3) : rimg[y+1][x+1];
                if (mode == 0) v = $urandom_range(0, 255);
                oimg[y][x] = (v > 255) ? 255 : v;
            end
    endtask

    task automatic drive_beat(input int b);
        for (int j = 0; j < BLK_W + 2; j++) ref_line[j*BD +: BD] = BD'(rimg[b][j]);
        for (int x = 0; x < BLK_W; x++)
            org_line[x*BD +: BD] = (b >= 2) ? BD'(oimg[b-2][x]) : BD'($urandom_range(0, 255));
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic send_block(input bit bub, input int nbeats);
        int  b, guard;
        bit  tog, acc;
        b = 0; guard = 0; tog = 1'b0;
        while (b < nbeats && guard < 300) begin
            guard++;
            if (bub && tog) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                drive_beat(b);
            end
            tog = ~tog;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                b++;
                last_edge = cyc;
            end
        end
        in_valid = 1'b0;
        if (b != nbeats) check("beats_accepted", b, nbeats);
    endtask

    task automatic get_result(input string tag, input int edx, input int edy, input int esad,
                              input int hold, input bit chk_lat);
        int guard;
        guard = 0;
        while (!out_valid && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        if (chk_lat) check({tag, "_latency"}, cyc - last_edge, 26);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_dx"}, int'(out_dx), edx);
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            @(posedge clk); #1;
        end
        check({tag, "_dx"}, int'(out_dx), edx);
        check({tag, "_dy"}, int'(out_dy), edy);
        check({tag, "_sad"}, int'(out_sad), esad);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, int'(in_ready), 1);
        check({tag, "_valid_after"}, int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mdx, mdy, msad;

        vecs[0] = '{pat: 0, edx: 0, edy: 0, esad: 0, hold: 0};
        vecs[1] = '{pat: 1, edx: 1, edy: 0, esad: 0, hold: 10};
`ifdef FRAC_INTERP_ROUND_EN
        vecs[2] = '{pat: 2, edx: -2, edy: -2, esad: 0, hold: 2};
`else
        vecs[2] = '{pat: 2, edx: 0, edy: 0, esad: 32, hold: 2};
`endif

        // Reset values while held in reset.
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dx", int'(out_dx), 0);
        check("rst_dy", int'(out_dy), 0);
        check("rst_sad", int'(out_sad), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 3; i++) begin
            fill_pattern(vecs[i].pat);
            send_block(1'b0, BLK_H + 2);
            get_result($sformatf("vec%0d", i), vecs[i].edx, vecs[i].edy, vecs[i].esad,
                       vecs[i].hold, 1'b1);
        end

        // Reset mid-block, then a clean ramp block.
        fill_pattern(1);
        send_block(1'b0, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(1'b0, BLK_H + 2);
        get_result("after_midrst", 1, 0, 0, 0, 1'b1);

        // Bubbles on alternate cycles.
        fill_pattern(1);
        send_block(1'b1, BLK_H + 2);
        get_result("bubbles", 1, 0, 0, 0, 1'b1);

        // Reset during DONE clears the held result.
        fill_pattern(1);
        send_block(1'b0, BLK_H + 2);
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("done_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("donerst_valid", int'(out_valid), 0);
        check("donerst_dx", int'(out_dx), 0);
        check("donerst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomised blocks against the model.
        for (int t = 0; t < 10; t++) begin
            fill_random();
            model(mdx, mdy, msad);
            send_block(1'($urandom_range(0, 1)), BLK_H + 2);
            get_result($sformatf("rand%0d", t), mdx, mdy, msad, $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
